// File: rtl/sevensegmentdecoder.sv
// sevensegmentdecoder: recovers the hex digit, blank, error and blink status from an
// asynchronous active-low seven-segment bus. Define SEVSEG_DEC_ALTGLYPH_EN to accept the alternate 7/9 glyphs.
module sevensegmentdecoder #(
    parameter logic [31:0] stableCycles = 32'd1000,
    parameter logic [31:0] blinkTimeout = 32'd60_000_000
) (
    input  logic       iClk,
    input  logic       nRst,
    input  logic [6:0] iSeg,
    output logic [3:0] oNum,
    output logic       oValid,
    output logic       oBlank,
    output logic       oErr,
    output logic       oBlinking,
    output logic       oStrobe
);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Returns {is_digit, is_blank, digit}; neither flag set means an illegal pattern.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_seg = {2'b10, 4'h0};
            7'h79:   decode_seg = {2'b10, 4'h1};
            7'h24:   decode_seg = {2'b10, 4'h2};
            7'h30:   decode_seg = {2'b10, 4'h3};
            7'h19:   decode_seg = {2'b10, 4'h4};
            7'h12:   decode_seg = {2'b10, 4'h5};
            7'h02:   decode_seg = {2'b10, 4'h6};
            7'h78:   decode_seg = {2'b10, 4'h7};
            7'h00:   decode_seg = {2'b10, 4'h8};
            7'h18:   decode_seg = {2'b10, 4'h9};
            7'h08:   decode_seg = {2'b10, 4'hA};
            7'h03:   decode_seg = {2'b10, 4'hB};
            7'h46:   decode_seg = {2'b10, 4'hC};
            7'h21:   decode_seg = {2'b10, 4'hD};
            7'h06:   decode_seg = {2'b10, 4'hE};
            7'h0E:   decode_seg = {2'b10, 4'hF};
`ifdef SEVSEG_DEC_ALTGLYPH_EN
            7'h58:   decode_seg = {2'b10, 4'h7};
            7'h10:   decode_seg = {2'b10, 4'h9};
`endif
            7'h7F:   decode_seg = {2'b01, 4'h0};
            default: decode_seg = {2'b00, 4'h0};
        endcase
    endfunction

    logic [6:0]  sync1_q, sync2_q;
    logic [6:0]  cand_q, cand_d;
    logic [6:0]  acc_q, acc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] gap_q, gap_d;
    logic [1:0]  hits_q, hits_d;
    logic [3:0]  num_q, num_d;
    logic        valid_q, valid_d;
    logic        blank_q, blank_d;
    logic        err_q, err_d;
    logic        blink_q, blink_d;
    logic        strobe_q, strobe_d;

    logic        accept_s;
    logic        transition_s;
    logic        err_accept_s;
    logic [5:0]  new_dec_s;
    logic [5:0]  old_dec_s;

    // Filter, blink detector and status next-state logic.
    always_comb begin
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        num_d        = num_q;
        valid_d      = valid_q;
        blank_d      = blank_q;
        err_d        = err_q;
        hits_d       = hits_q;
        accept_s     = 1'b0;
        transition_s = 1'b0;
        err_accept_s = 1'b0;
        new_dec_s    = decode_seg(cand_q);
        old_dec_s    = decode_seg(acc_q);

        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = 32'd0;
        end else if (cnt_q >= stableCycles) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        // Qualification is judged on the next count so the status registers the same edge it qualifies.
        if ((sync2_q == cand_q) && (cnt_d == stableCycles) && (cand_q != acc_q)) begin
            accept_s     = 1'b1;
            acc_d        = cand_q;
            transition_s = (old_dec_s[4] && new_dec_s[5]) || (old_dec_s[5] && new_dec_s[4]);
            err_accept_s = !new_dec_s[5] && !new_dec_s[4];
            valid_d      = new_dec_s[5];
            blank_d      = new_dec_s[4];
            err_d        = err_accept_s;
            if (new_dec_s[5]) begin
                num_d = new_dec_s[3:0];
            end else begin
                num_d = num_q;
            end
        end else begin
            accept_s = 1'b0;
        end

        if (transition_s) begin
            gap_d = 32'd0;
        end else if (gap_q == 32'hFFFF_FFFF) begin
            gap_d = gap_q;
        end else begin
            gap_d = gap_q + 32'd1;
        end

        // A transition is judged against the gap before it clears, so it wins over a coincident timeout.
        if (transition_s) begin
            if (gap_q <= blinkTimeout) begin
                hits_d = (hits_q == 2'd2) ? 2'd2 : hits_q + 2'd1;
            end else begin
                hits_d = 2'd1;
            end
        end else if (err_accept_s || (gap_q > blinkTimeout)) begin
            hits_d = 2'd0;
        end else begin
            hits_d = hits_q;
        end

        blink_d  = (hits_d == 2'd2);
        strobe_d = accept_s;
    end

    // State and output registers.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            sync1_q  <= SEG_BLANK;
            sync2_q  <= SEG_BLANK;
            cand_q   <= SEG_BLANK;
            acc_q    <= SEG_BLANK;
            cnt_q    <= 32'd0;
            gap_q    <= 32'd0;
            hits_q   <= 2'd0;
            num_q    <= 4'h0;
            valid_q  <= 1'b0;
            blank_q  <= 1'b1;
            err_q    <= 1'b0;
            blink_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= iSeg;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            hits_q   <= hits_d;
            num_q    <= num_d;
            valid_q  <= valid_d;
            blank_q  <= blank_d;
            err_q    <= err_d;
            blink_q  <= blink_d;
            strobe_q <= strobe_d;
        end
    end

    assign oNum      = num_q;
    assign oValid    = valid_q;
    assign oBlank    = blank_q;
    assign oErr      = err_q;
    assign oBlinking = blink_q;
    assign oStrobe   = strobe_q;

endmodule

// File: tb/tb_sevensegmentdecoder.sv
// Self-checking bench for sevensegmentdecoder: a streak/timestamp reference model checked every cycle,
// plus directed scenarios with hand-computed expectations and a randomized phase.
module tb_sevensegmentdecoder;

    localparam int STABLE = 4;
    localparam int TO     = 100;
    localparam logic [6:0] CODES [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic       iClk = 1'b0;
    logic       nRst = 1'b0;
    logic [6:0] iSeg = 7'h7F;
    logic [3:0] oNum;
    logic       oValid, oBlank, oErr, oBlinking, oStrobe;

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;

    sevensegmentdecoder #(
        .stableCycles(32'd4),
        .blinkTimeout(32'd100)
    ) dut (
        .iClk(iClk), .nRst(nRst), .iSeg(iSeg), .oNum(oNum), .oValid(oValid),
        .oBlank(oBlank), .oErr(oErr), .oBlinking(oBlinking), .oStrobe(oStrobe)
    );

    always #5 iClk = ~iClk;

    // 0..15 digit, 16 blank, 17 illegal
    function automatic int classify(input logic [6:0] s);
        int k;
        k = 17;
        for (int i = 0; i < 16; i++) if (CODES[i] == s) k = i;
`ifdef SEVSEG_DEC_ALTGLYPH_EN
        if (s == 7'h58) k = 7;
        if (s == 7'h10) k = 9;
`endif
        if (s == 7'h7F) k = 16;
        return k;
    endfunction

    // Reference model state
    logic [6:0] m_pipe[$];
    logic [6:0] m_rv, m_acc;
    int         m_rl, m_hits;
    longint     m_tick, m_last;
    logic [3:0] e_num;
    logic       e_valid, e_blank, e_err, e_blink, e_strobe;

    task automatic m_reset();
        m_pipe = '{7'h7F, 7'h7F};
        m_rv = 7'h7F; m_acc = 7'h7F; m_rl = 1; m_hits = 0;
        m_tick = 0; m_last = 0;
        e_num = 4'h0; e_valid = 1'b0; e_blank = 1'b1; e_err = 1'b0; e_blink = 1'b0; e_strobe = 1'b0;
    endtask

    task automatic m_step();
        logic [6:0] v;
        longint gap_pre;
        int oldk, newk;
        bit tr, erracc;
        v = m_pipe.pop_front();
        m_pipe.push_back(iSeg);
        m_tick++;
        gap_pre = m_tick - 1 - m_last;
        if (v == m_rv) begin
            if (m_rl < 1000) m_rl++;
        end else begin
            m_rv = v; m_rl = 1;
        end
        e_strobe = 1'b0; tr = 1'b0; erracc = 1'b0;
        if (m_rl >= STABLE + 1 && v != m_acc) begin
            oldk = classify(m_acc);
            newk = classify(v);
            e_strobe = 1'b1;
            tr = (oldk == 16 && newk < 16) || (oldk < 16 && newk == 16);
            if (newk < 16) begin
                e_num = 4'(newk); e_valid = 1'b1; e_blank = 1'b0; e_err = 1'b0;
            end else if (newk == 16) begin
                e_valid = 1'b0; e_blank = 1'b1; e_err = 1'b0;
            end else begin
                e_valid = 1'b0; e_blank = 1'b0; e_err = 1'b1; erracc = 1'b1;
            end
            m_acc = v;
        end
        if (tr) begin
            m_hits = (gap_pre <= TO) ? ((m_hits < 2) ? m_hits + 1 : 2) : 1;
            m_last = m_tick;
        end else if (erracc || gap_pre > TO) begin
            m_hits = 0;
        end
        e_blink = (m_hits == 2);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge iClk or negedge nRst);
            if (!nRst) m_reset();
            else m_step();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge iClk);
            tests++;
            if ({oNum, oValid, oBlank, oErr, oBlinking, oStrobe} !==
                {e_num, e_valid, e_blank, e_err, e_blink, e_strobe}) begin
                fails++;
                $display("FAIL model_cycle t=%0t dut num=%h v=%b b=%b e=%b bl=%b s=%b, expected num=%h v=%b b=%b e=%b bl=%b s=%b",
                         $time, oNum, oValid, oBlank, oErr, oBlinking, oStrobe,
                         e_num, e_valid, e_blank, e_err, e_blink, e_strobe);
            end
        end
    end

    initial begin
        forever begin
            @(posedge iClk);
            #1;
            if (oStrobe) strobe_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [6:0] c, input int n);
        iSeg = c;
        repeat (n) @(negedge iClk);
    endtask

    initial begin
        logic [6:0] c;
        int r;
        repeat (3) @(negedge iClk);
        nRst = 1'b1;

        hold(7'h7F, 10);
        chk("reset_blank", 32'(oBlank), 32'd1);
        chk("reset_valid", 32'(oValid), 32'd0);
        chk("reset_num", 32'(oNum), 32'd0);
        chk("reset_nostrobe", strobe_cnt, 32'd0);

        hold(7'h30, 6);
        chk("lat_not_before_7", 32'(oValid), 32'd0);
        @(negedge iClk);
        chk("lat_strobe_at_7", 32'(oStrobe), 32'd1);
        chk("lat_num3", 32'(oNum), 32'd3);
        chk("lat_valid", 32'(oValid), 32'd1);
        hold(7'h30, 5);
        chk("strobe_once", strobe_cnt, 32'd1);

        hold(7'h24, 12);
        strobe_cnt = 0;
        hold(7'h79, 3);
        hold(7'h24, 12);
        chk("short_glitch_num", 32'(oNum), 32'd2);
        chk("short_glitch_nostrobe", strobe_cnt, 32'd0);
        hold(7'h79, 5);
        hold(7'h24, 12);
        chk("long_glitch_num", 32'(oNum), 32'd2);
        chk("long_glitch_strobes", strobe_cnt, 32'd2);

        strobe_cnt = 0;
        for (int i = 0; i < 16; i++) hold(CODES[i], 10);
        chk("sweep_strobes", strobe_cnt, 32'd16);
        chk("sweep_num_F", 32'(oNum), 32'hF);
        hold(7'h7E, 10);
        chk("err_7E", 32'(oErr), 32'd1);
        chk("err_num_holds", 32'(oNum), 32'hF);
        chk("err_not_valid", 32'(oValid), 32'd0);

        hold(7'h12, 40);
        hold(7'h7F, 40);
        hold(7'h12, 40);
        chk("blink_on", 32'(oBlinking), 32'd1);
        hold(7'h12, 150);
        chk("blink_timeout", 32'(oBlinking), 32'd0);
        hold(7'h7F, 40);
        hold(7'h12, 40);
        hold(7'h7F, 40);
        chk("blink_again", 32'(oBlinking), 32'd1);
        hold(7'h55, 6);
        chk("blink_before_err", 32'(oBlinking), 32'd1);
        @(negedge iClk);
        chk("err55_strobe", 32'(oStrobe), 32'd1);
        chk("err55_err", 32'(oErr), 32'd1);
        chk("err55_blink_off", 32'(oBlinking), 32'd0);
        hold(7'h12, 12);
        chk("num5_before_reset", 32'(oNum), 32'd5);

        hold(7'h30, 3);
        #2 nRst = 1'b0;
        #1;
        chk("rst_num", 32'(oNum), 32'd0);
        chk("rst_flags", 32'({oValid, oBlank, oErr, oBlinking, oStrobe}), 32'b01000);
        @(negedge iClk);
        nRst = 1'b1;
        repeat (3) @(negedge iClk);
        chk("rst_no_residual", 32'({oNum, oValid, oBlank}), 32'b0000_0_1);
        hold(7'h30, 10);
        chk("after_rst_num3", 32'(oNum), 32'd3);

        hold(7'h58, 12);
`ifdef SEVSEG_DEC_ALTGLYPH_EN
        chk("alt58_num", 32'(oNum), 32'd7);
        chk("alt58_valid", 32'(oValid), 32'd1);
`else
        chk("alt58_err", 32'(oErr), 32'd1);
        chk("alt58_not_valid", 32'(oValid), 32'd0);
`endif
        hold(7'h10, 12);
`ifdef SEVSEG_DEC_ALTGLYPH_EN
        chk("alt10_num", 32'(oNum), 32'd9);
        chk("alt10_valid", 32'(oValid), 32'd1);
`else
        chk("alt10_err", 32'(oErr), 32'd1);
        chk("alt10_not_valid", 32'(oValid), 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) c = CODES[$urandom_range(0, 15)];
            else if (r < 7) c = 7'h7F;
            else c = 7'($urandom);
            hold(c, int'($urandom_range(1, 12)));
        end
        hold(7'h7F, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sevensegmentdecoder.md
# sevensegmentdecoder

Reads a 7-bit active-low seven-segment bus and recovers the hex digit shown, plus blank, blinking and illegal-pattern status. It is the receive-side counterpart of the seven-segment controller: it is used for on-board self-check of display outputs and for reading segment lines driven by another board. The input is treated as asynchronous and is glitch-filtered before decoding.

## Interface
- stableCycles, 32'd1000: consecutive cycles a synchronized pattern must hold before it is accepted; legal range ≥ 1.
- blinkTimeout, 32'd60_000_000: maximum cycles between blank/digit transitions for the display to count as blinking.
- iClk  input  1  clock.
- nRst  input  1  asynchronous, active-low reset.
- iSeg  input  7  segment lines, active-low, bit order {g,f,e,d,c,b,a}; asynchronous to iClk.
- oNum  output  4  last accepted valid digit.
- oValid  output  1  accepted pattern is a legal digit.
- oBlank  output  1  accepted pattern is 7'h7F, all segments off.
- oErr  output  1  accepted pattern is neither a digit nor blank.
- oBlinking  output  1  blank/digit alternation detected.
- oStrobe  output  1  one-cycle pulse when the accepted pattern changes.

## Operation
- Synchronizer: two flops on iSeg. Both flops reset to 7'h7F.
- Filter: a candidate register and a stable counter.
  - When the synchronized value differs from the candidate: load the candidate and clear the counter.
  - Otherwise the counter increments, saturating at stableCycles.
  - When the counter reaches stableCycles and the candidate differs from the accepted register: load the accepted register and pulse oStrobe.
- Decode table, in hex:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 18, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E
- Status outputs:
  - Digit: oValid = 1, oNum = digit, oBlank = 0, oErr = 0.
  - Blank (7F): oBlank = 1, oValid = 0, oNum holds.
  - Any other pattern: oErr = 1, oValid = 0, oNum holds.
  - Exactly one of oValid, oBlank and oErr is high at any time.
- Blink detector:
  - A transition is an accepted change between blank and a valid digit; digit-to-digit changes are not transitions.
  - The gap counter is 32-bit, saturating, and clears on each transition.
  - A transition with gap ≤ blinkTimeout increments the hit count (saturates at 2). A transition with gap > blinkTimeout sets the hit count to 1.
  - oBlinking = 1 while hits = 2.
  - Clear hits and oBlinking when gap exceeds blinkTimeout, or when an error pattern is accepted.
- Reset values:
  - oNum = 0, oValid = 0, oBlank = 1, oErr = 0, oBlinking = 0, oStrobe = 0.
  - Accepted register and candidate = 7F; all counters = 0.
  - Reset is honoured mid-filter and mid-blink with no residual state.

## Timing
- Every output is registered.
- A new iSeg value held steady appears on the outputs exactly stableCycles + 3 iClk edges after the first edge that samples it: 2 for the synchronizer, stableCycles to qualify, 1 to register.
- oStrobe is high in the same cycle the new status first appears.
- A glitch shorter than stableCycles cycles produces no output change and no strobe.
- A return to the already-accepted pattern before qualification produces no strobe.
- If a blink transition and timeout expiry occur in the same cycle, the transition wins: the gap is evaluated against the pre-clear counter.
- The gap counter saturates at 32'hFFFFFFFF and never wraps.

## Configuration
- SEVSEG_DEC_ALTGLYPH_EN defined: two additional glyphs decode as valid digits.
  - 58 (7 with segment f lit) decodes as 7.
  - 10 (9 with segment d lit) decodes as 9.
- Undefined: 58 and 10 are error patterns, with oErr = 1.

## Test plan
Bench parameters: stableCycles = 4, blinkTimeout = 100.
- Reset then iSeg = 7F → oBlank = 1, oValid = 0, oNum = 0, no strobe; drive 30 → oNum = 3, oValid = 1, oStrobe exactly once, 7 cycles after the first sampling edge.
- Hold 24, glitch to 79 for 3 cycles, return to 24 → no strobe, oNum stays 2; glitch for 5 cycles → oNum = 1, then back to 2, two strobes total.
- Sweep all 16 table codes, each held for 10 cycles → oNum = 0..F in order, oValid = 1 throughout, 16 strobes; drive 7E → oErr = 1, oNum holds F.
- Alternate 12 and 7F every 40 cycles → oBlinking = 1 after the second transition; stop on 12 → oBlinking = 0 once the gap exceeds 100.
- During blinking, accept 55 → oBlinking = 0 and oErr = 1 in the same cycle; assert nRst mid-filter → all outputs at reset values immediately.
- With SEVSEG_DEC_ALTGLYPH_EN defined, drive 58 then 10 → oNum = 7, then 9, oValid = 1; without the macro → oErr = 1 for both.
